// File: rtl/game_pkg.sv
// Shared definitions for the memory game: symbol width, the playback/entry
// state encoding and the blank symbol value.
package game_pkg;

   localparam int DATA_W = 4;

   // State encoding shared with the user-side round logic.
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_FETCH = 3'd1;
   localparam state_t S_LATCH = 3'd2;
   localparam state_t S_SHOW  = 3'd3;
   localparam state_t S_GAP   = 3'd4;
   localparam state_t S_DONE  = 3'd5;

   localparam logic [DATA_W-1:0] BLANK = '0;

endpackage

// File: rtl/seq_player_if.sv
// Playback bus: controller request, sequence ROM port and LED/status outputs.
interface seq_player_if;
   import game_pkg::*;

   logic              start;
   logic [DATA_W-1:0] round;
   logic [DATA_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] led;
   logic              busy;
   logic              done;

   // Game controller side, which also owns the sequence ROM.
   modport master (
      output start, round, rom_data,
      input  rom_addr, led, busy, done
   );

   // Player side.
   modport slave (
      input  start, round, rom_data,
      output rom_addr, led, busy, done
   );

endinterface

// File: rtl/seq_player_timer.sv
// Down-counter used for the symbol on-time and blank gap. expired is high
// during the last cycle of a loaded count.
module cycle_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         R,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] cnt;

   // Load a new count, otherwise count down and rest at zero.
   always_ff @(posedge clk) begin
      // NOTE: clocked state is always written with <= so every register
      // updates from pre-edge values regardless of statement order.
      if (!R)
         cnt <= '0;
      else if (load)
         cnt <= value;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == W'(1));

endmodule

// File: rtl/seq_player.sv
// Plays symbols 0..round from the sequence ROM on the LEDs, each shown for
// ON_CYC cycles followed by OFF_CYC blank cycles, then pulses done.
module seq_player
   import game_pkg::*;
#(
   parameter int ON_CYC  = 3,
   parameter int OFF_CYC = 2
) (
   input logic         clk,
   input logic         R,
   seq_player_if.slave bus
);

   localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int TW      = $clog2(MAX_CYC + 1);

   state_t            state;
   logic [DATA_W-1:0] idx;
   logic [DATA_W-1:0] rnd;
   logic [DATA_W-1:0] led_q;
   logic [DATA_W-1:0] addr_q;
   logic              busy_q;
   logic              done_q;

   logic              t_load;
   logic [TW-1:0]     t_value;
   logic              t_expired;

   // Timer starts the on-time in LATCH and the gap when the on-time ends.
   assign t_load  = (state == S_LATCH) || ((state == S_SHOW) && t_expired);
   assign t_value = (state == S_LATCH) ? TW'(ON_CYC) : TW'(OFF_CYC);

   cycle_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .R       (R),
      .load    (t_load),
      .value   (t_value),
      .expired (t_expired)
   );

   // Playback FSM with the index, latched round and all output registers.
   always_ff @(posedge clk) begin
      if (!R) begin
         state  <= S_IDLE;
         idx    <= '0;
         rnd    <= '0;
         led_q  <= BLANK;
         addr_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  idx    <= '0;
                  rnd    <= bus.round;
                  addr_q <= '0;
                  busy_q <= 1'b1;
                  state  <= S_FETCH;
               end
            end
            S_FETCH: state <= S_LATCH;
            S_LATCH: begin
               led_q <= bus.rom_data;
               state <= S_SHOW;
            end
            S_SHOW: begin
               if (t_expired) begin
                  led_q <= BLANK;
                  state <= S_GAP;
               end
            end
            S_GAP: begin
               if (t_expired) begin
                  // End test uses idx before increment, so idx never wraps.
                  if (idx == rnd) begin
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     idx    <= idx + 1'b1;
                     addr_q <= idx + 1'b1;
                     state  <= S_FETCH;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.led      = led_q;
   assign bus.rom_addr = addr_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule
